pdm_cic_decimator: RTL and testbench
====================================

PDM_CIC_DECIMATOR -- requirements
Module: pdm_cic_decimator

Interface
REQ-001 Parameter LOG2_DECIM, default 6: decimation ratio R = 2^LOG2_DECIM; legal range 4..8.
REQ-002 clk  input  1  single system clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 pdm_en  input  1  one-cycle strobe; pdm_data is sampled only in cycles where it is high.
REQ-005 pdm_data  input  1  PDM bit from microphone; 1 = +1, 0 = -1.
REQ-006 pcm_out  output  16  signed PCM sample; held stable between pcm_valid pulses.
REQ-007 pcm_valid  output  1  one-cycle strobe marking a new pcm_out.

Function
REQ-008 The filter SHALL be a 4th-order CIC decimator, differential delay 1, with internal width W = 2 + 4*LOG2_DECIM bits (26 at default).
REQ-009 Each pdm_en cycle SHALL map pdm_data to a 2-bit signed value (+1/-1) and update integrators I1..I4 in cascade in that same cycle.
REQ-010 Integrators SHALL wrap modulo 2^W with no saturation; comb differences SHALL be taken modulo 2^W.
REQ-011 Cycles without pdm_en SHALL leave all integrator, counter and comb state unchanged; back-to-back pdm_en on every cycle SHALL be supported.
REQ-012 A decimation counter of LOG2_DECIM bits SHALL increment on each pdm_en and wrap to 0; the pdm_en on which it reads R-1 is the decimation event.
REQ-013 Decimation event in cycle k: I4 (post-update) SHALL be latched and passed through combs C1..C4 in cycle k+1, registered.
REQ-014 Cycle k+2: pcm_out SHALL be the comb result arithmetically shifted right by (4*LOG2_DECIM - 15), saturated to [-32768, +32767]; pcm_valid SHALL be high for exactly cycle k+2.
REQ-015 Full-scale all-ones input (R^4 = 2^(4*LOG2_DECIM)) SHALL saturate to +32767; all-zeros SHALL give exactly -32768.
REQ-016 pcm_valid SHALL be suppressed for the first 4 decimation events after reset (comb warm-up); pcm_out SHALL still update internally but need not be meaningful.
REQ-017 A pdm_en arriving in k+1 or k+2 SHALL be accepted normally and SHALL NOT disturb the in-flight output.
REQ-018 pcm_valid SHALL never be high in two consecutive cycles for any legal LOG2_DECIM.

Reset
REQ-019 While rst is high: integrators, comb delay registers, decimation counter, warm-up counter, pipeline registers, pcm_out = 0 and pcm_valid = 0.
REQ-020 Reset asserted mid-operation SHALL discard any in-flight sample (no pcm_valid pulse for it) and restart warm-up.
REQ-021 First pdm_en after rst deassertion SHALL be counted as input sample 0.

Structure
REQ-022 Shared package audio_pkg SHALL hold CIC_ORDER = 4, PCM_W = 16, and the width/shift derivation function used for W and the output shift.
REQ-023 One sub-module, cic_integrator (width-parameterised accumulator with enable), SHALL be instantiated four times; combs, counters and saturation stay in pdm_cic_decimator.
REQ-024 Estimated size 150-250 lines RTL; no memories, no multipliers.

Verification
REQ-025 Constant pdm_data=1, pdm_en every 4th cycle, default R -> after 4 suppressed events every pcm_out = 32767, pcm_valid period 256 cycles.
REQ-026 Constant pdm_data=0 -> steady pcm_out = -32768; alternating 1,0,1,0 -> steady pcm_out = 0.
REQ-027 Latency: pdm_en every cycle, mark 64th pdm_en after warm-up at cycle k -> pcm_valid exactly at k+2, single cycle.
REQ-028 Integrator wrap: 2,000,000 pdm_en with pdm_data=1 -> pcm_out stays 32767 with no glitch across integrator overflow.
REQ-029 Random pdm_en gaps (0-7 idle cycles) with sine-coded PDM -> pcm_out bit-exact against golden model fed the same strobed sample sequence.
REQ-030 rst pulsed in cycle k+1 of a decimation event -> no pcm_valid at k+2, all outputs 0, next valid only after 4 more suppressed events.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio constants and the CIC width/shift derivations.
package audio_pkg;

  localparam int CIC_ORDER = 4;
  localparam int PCM_W     = 16;

  // Register growth of an N-stage CIC is N*log2(R) bits on top of the 2-bit input.
  function automatic int cic_width(input int log2_decim);
    return 2 + CIC_ORDER * log2_decim;
  endfunction

  function automatic int cic_shift(input int log2_decim);
    return CIC_ORDER * log2_decim - (PCM_W - 1);
  endfunction

endpackage

// File: rtl/cic_integrator.sv
// Wrapping accumulator with enable; acc_next exposes the post-update value so
// stages can cascade within a single cycle.
module cic_integrator #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] acc_next
);

  logic [W-1:0] acc;

  assign acc_next = acc + din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/pdm_cic_decimator.sv
// 4th-order CIC decimator: PDM bit stream in, saturated 16-bit PCM out two
// cycles after each decimation event.
module pdm_cic_decimator
  import audio_pkg::*;
#(
  parameter int LOG2_DECIM = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pdm_en,
  input  logic                    pdm_data,
  output logic signed [PCM_W-1:0] pcm_out,
  output logic                    pcm_valid
);

  localparam int W      = cic_width(LOG2_DECIM);
  localparam int SHIFT  = cic_shift(LOG2_DECIM);
  localparam int WARMUP = CIC_ORDER;
  localparam logic signed [W-1:0] PCM_MAX = W'((1 << (PCM_W - 1)) - 1);
  localparam logic signed [W-1:0] PCM_MIN = ~PCM_MAX;

  logic [W-1:0]            stage [CIC_ORDER+1];
  logic [LOG2_DECIM-1:0]   dec_cnt;
  logic                    dec_event;
  logic [W-1:0]            i4_lat;
  logic                    ev_d1;
  logic [W-1:0]            comb_dly [CIC_ORDER];
  logic [W-1:0]            comb [CIC_ORDER+1];
  logic signed [W-1:0]     comb_sh;
  logic signed [PCM_W-1:0] pcm_sat;
  logic [2:0]              warm_cnt;

  assign stage[0] = pdm_data ? W'(1) : '1;

  for (genvar g = 0; g < CIC_ORDER; g++) begin : g_int
    cic_integrator #(.W(W)) u_int (
      .clk      (clk),
      .rst      (rst),
      .en       (pdm_en),
      .din      (stage[g]),
      .acc_next (stage[g+1])
    );
  end

  // Counter reads R-1 (all ones) on the last sample of each block.
  assign dec_event = pdm_en && (dec_cnt == '1);

  always_comb begin
    comb[0] = i4_lat;
    for (int i = 0; i < CIC_ORDER; i++) begin
      comb[i+1] = comb[i] - comb_dly[i];
    end
  end

  assign comb_sh = $signed(comb[CIC_ORDER]) >>> SHIFT;

  always_comb begin
    pcm_sat = comb_sh[PCM_W-1:0];
    if (comb_sh > PCM_MAX) begin
      pcm_sat = PCM_MAX[PCM_W-1:0];
    end else if (comb_sh < PCM_MIN) begin
      pcm_sat = PCM_MIN[PCM_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_cnt   <= '0;
      i4_lat    <= '0;
      ev_d1     <= 1'b0;
      warm_cnt  <= '0;
      pcm_out   <= '0;
      pcm_valid <= 1'b0;
      for (int i = 0; i < CIC_ORDER; i++) begin
        comb_dly[i] <= '0;
      end
    end else begin
      if (pdm_en) begin
        dec_cnt <= dec_cnt + 1'b1;
      end
      if (dec_event) begin
        i4_lat <= stage[CIC_ORDER];
      end
      ev_d1     <= dec_event;
      pcm_valid <= ev_d1 && (warm_cnt == 3'(WARMUP));
      // Comb delays only advance at the decimated rate.
      if (ev_d1) begin
        for (int i = 0; i < CIC_ORDER; i++) begin
          comb_dly[i] <= comb[i];
        end
        pcm_out <= pcm_sat;
        if (warm_cnt != 3'(WARMUP)) begin
          warm_cnt <= warm_cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Random/directed bench; reference computes each output as the FIR form of the
// CIC (boxcar^4 impulse response) over the strobed sample history.
module tb_pdm_cic_decimator;

  localparam int L     = 6;
  localparam int R     = 1 << L;
  localparam int HLEN  = 4 * R - 3;
  localparam int SHIFT = 4 * L - 15;

  logic               clk = 1'b0;
  logic               rst;
  logic               pdm_en;
  logic               pdm_data;
  logic signed [15:0] pcm_out;
  logic               pcm_valid;

  pdm_cic_decimator #(.LOG2_DECIM(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .pdm_en    (pdm_en),
    .pdm_data  (pdm_data),
    .pcm_out   (pcm_out),
    .pcm_valid (pcm_valid)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  longint h [HLEN];
  int     hist [HLEN];
  int     wp, smp_cnt, ev_cnt, cyc;
  bit     e1, e2, sup1, sup2, exp_valid, known;
  longint val1, val2, exp_out;
  int     valid_cnt, last_valid_cyc, last_ev_cyc, period;
  longint vmin, vmax;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic build_coefs();
    longint tmp [HLEN];
    longint nxt [HLEN];
    int len;
    for (int i = 0; i < HLEN; i++) tmp[i] = 0;
    tmp[0] = 1;
    len = 1;
    repeat (4) begin
      for (int i = 0; i < HLEN; i++) begin
        nxt[i] = 0;
        for (int m = 0; m < R; m++)
          if (i - m >= 0 && i - m < len) nxt[i] += tmp[i-m];
      end
      len += R - 1;
      tmp = nxt;
    end
    h = tmp;
  endtask

  task automatic model_pcm(output longint pcm);
    longint y, s;
    y = 0;
    for (int j = 0; j < HLEN; j++)
      y += h[j] * longint'(hist[(wp - 1 - j + HLEN) % HLEN]);
    s = y >>> SHIFT;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    pcm = s;
  endtask

  task automatic model_apply(input bit r, input bit en, input bit d);
    if (r) begin
      for (int i = 0; i < HLEN; i++) hist[i] = 0;
      wp = 0; smp_cnt = 0; ev_cnt = 0;
      e1 = 0; e2 = 0; exp_valid = 0;
      known = 1; exp_out = 0;
    end else begin
      e2 = e1; val2 = val1; sup2 = sup1; e1 = 0;
      exp_valid = e2 && !sup2;
      if (e2) begin
        if (sup2) known = 0;
        else begin
          known = 1;
          exp_out = val2;
        end
      end
      if (en) begin
        hist[wp] = d ? 1 : -1;
        wp = (wp + 1) % HLEN;
        if (smp_cnt % R == R - 1) begin
          e1 = 1;
          model_pcm(val1);
          sup1 = (ev_cnt < 4);
          if (!sup1) last_ev_cyc = cyc;
          ev_cnt++;
        end
        smp_cnt++;
      end
    end
  endtask

  task automatic check_outputs();
    check("valid", longint'(pcm_valid), longint'(exp_valid));
    if (known) check("pcm_out", longint'(pcm_out), exp_out);
    if (pcm_valid) begin
      if (last_valid_cyc >= 0) period = cyc - last_valid_cyc;
      last_valid_cyc = cyc;
      valid_cnt++;
      if (longint'(pcm_out) < vmin) vmin = longint'(pcm_out);
      if (longint'(pcm_out) > vmax) vmax = longint'(pcm_out);
    end
  endtask

  task automatic cycle(input bit r, input bit en, input bit d);
    @(negedge clk);
    check_outputs();
    rst = r; pdm_en = en; pdm_data = d;
    model_apply(r, en, d);
    cyc++;
  endtask

  task automatic clear_stats();
    valid_cnt = 0; last_valid_cyc = -1; period = -1;
    vmin = 1 << 20; vmax = -(1 << 20);
  endtask

  task automatic do_reset();
    repeat (2) cycle(1, 0, 0);
    clear_stats();
  endtask

  initial begin
    bit     found;
    real    sd_acc, s, v;
    bit     b;
    rst = 1; pdm_en = 0; pdm_data = 0;
    cyc = 0; last_ev_cyc = -1;
    build_coefs();
    model_apply(1, 0, 0);
    clear_stats();

    repeat (3) cycle(1, 1, 1);
    check("reset_out", longint'(pcm_out), 0);
    check("reset_valid", longint'(pcm_valid), 0);

    // All ones, one sample every 4th cycle
    clear_stats();
    for (int n = 0; n < 7 * R; n++) begin
      cycle(0, 1, 1);
      repeat (3) cycle(0, 0, 1);
    end
    check("ones_count", valid_cnt, 3);
    check("ones_period", period, 256);
    check("ones_value", longint'(pcm_out), 32767);

    // All ones back-to-back, long enough for integrators to wrap many times
    clear_stats();
    for (int n = 0; n < 40 * R; n++) cycle(0, 1, 1);
    repeat (3) cycle(0, 0, 0);
    check("wrap_count", valid_cnt, 40);
    check("wrap_min", vmin, 32767);
    check("wrap_max", vmax, 32767);
    check("latency", last_valid_cyc - last_ev_cyc, 2);

    // Reset during the cycle after a decimation event
    found = 0;
    for (int i = 0; i < 2 * R && !found; i++) begin
      cycle(0, 1, 1);
      if (e1 && !sup1) found = 1;
    end
    check("rst_event_found", longint'(found), 1);
    clear_stats();
    cycle(1, 0, 0);
    repeat (3) cycle(0, 0, 0);
    check("rst_mid_out", longint'(pcm_out), 0);
    for (int n = 0; n < 4 * R; n++) cycle(0, 1, 1);
    repeat (3) cycle(0, 0, 0);
    check("rst_mid_suppressed", valid_cnt, 0);
    for (int n = 0; n < R; n++) cycle(0, 1, 1);
    repeat (3) cycle(0, 0, 0);
    check("rst_mid_first", valid_cnt, 1);
    check("rst_mid_value", longint'(pcm_out), 32767);

    // All zeros
    do_reset();
    for (int n = 0; n < 6 * R; n++) cycle(0, 1, 0);
    repeat (3) cycle(0, 0, 0);
    check("zeros_count", valid_cnt, 2);
    check("zeros_value", longint'(pcm_out), -32768);

    // Alternating 1,0
    do_reset();
    for (int n = 0; n < 6 * R; n++) cycle(0, 1, n[0] == 1'b0);
    repeat (3) cycle(0, 0, 0);
    check("alt_value", longint'(pcm_out), 0);

    // Sigma-delta coded sine with random strobe gaps and junk data when idle
    do_reset();
    sd_acc = 0.0;
    for (int n = 0; n < 30 * R; n++) begin
      repeat ($urandom_range(0, 7)) cycle(0, 0, 1'($urandom));
      s = 0.6 * $sin(2.0 * 3.14159265 * n / 200.0);
      v = sd_acc + s;
      b = (v >= 0.0);
      sd_acc = v - (b ? 1.0 : -1.0);
      cycle(0, 1, b);
    end
    repeat (3) cycle(0, 0, 0);
    check("sine_count", valid_cnt, 26);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
